// File: rtl/alarm_timer_pkg.sv
// Shared types and constants for the alarm countdown timer arbiter.
// Holds the FSM state, interval selectors and interval table defaults.
package alarm_timer_pkg;

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   localparam logic [1:0] SEL_ARM    = 2'd0;
   localparam logic [1:0] SEL_DRIVER = 2'd1;
   localparam logic [1:0] SEL_PASS   = 2'd2;
   localparam logic [1:0] SEL_ALARM  = 2'd3;

   localparam logic [3:0] T_ARM_DELAY       = 4'd6;
   localparam logic [3:0] T_DRIVER_DELAY    = 4'd8;
   localparam logic [3:0] T_PASSENGER_DELAY = 4'd15;
   localparam logic [3:0] T_ALARM_ON        = 4'd10;

endpackage

// File: rtl/timer_arbiter_sec_prescaler.sv
// Seconds prescaler: counts clock cycles 0..CLK_HZ-1 and flags the
// terminal count as a one-cycle tick.
module sec_prescaler #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [W-1:0] cnt;

   assign tick = enable && (cnt == W'(CLK_HZ - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one countdown timer among prioritised requesters with
// preemption, pending slots, cancellation and a programmable table.
module timer_arbiter
   import alarm_timer_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int NREQ   = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   start,
   input  logic [2*NREQ-1:0] sel,
   input  logic [NREQ-1:0]   cancel,
   input  logic              reprogram,
   input  logic [1:0]        prog_sel,
   input  logic [3:0]        prog_value,
   output logic [NREQ-1:0]   expired,
   output logic              busy,
   output logic [1:0]        owner,
   output logic [3:0]        remaining,
   output logic              one_hz_enable,
   output logic              half_hz_enable
);

   state_t          st, st_n;
   logic [1:0]      own, own_n;
   logic [3:0]      rem, rem_n;
   logic [NREQ-1:0] pend, pend_n;
   logic [1:0]      psel [NREQ];
   logic [1:0]      psel_n [NREQ];
   logic [3:0]      tbl [4];
   logic            half, half_n;
   logic [NREQ-1:0] exp_n;
   logic [NREQ-1:0] go, cand;
   logic            found, load, tick;
   int              gi;

   sec_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_presc (
      .clock  (clock),
      .reset  (reset),
      .enable (st == COUNT),
      .clear  (load || st != COUNT),
      .tick   (tick)
   );

   always_comb begin
      st_n   = st;
      own_n  = own;
      rem_n  = rem;
      half_n = half;
      exp_n  = '0;
      psel_n = psel;
      load   = 1'b0;
      found  = 1'b0;
      gi     = 0;
      // a cancel in the same cycle suppresses that requester's start
      go     = start & ~cancel;
      pend_n = pend & ~cancel;
      cand   = (st == IDLE) ? (go | pend_n) : go;
      for (int i = 0; i < NREQ; i++) begin
         if (cand[i] && !found) begin
            found = 1'b1;
            gi    = i;
         end
      end
      if (found && (st == IDLE || 2'(gi) <= own)) begin
         load       = 1'b1;
         st_n       = COUNT;
         own_n      = 2'(gi);
         rem_n      = tbl[go[gi] ? sel[2*gi +: 2] : psel[gi]];
         half_n     = 1'b0;
         pend_n[gi] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (go[i] && !(load && gi == i)) begin
            pend_n[i] = 1'b1;
            psel_n[i] = sel[2*i +: 2];
         end
      end
      if (!load && st == COUNT) begin
         if (cancel[own]) begin
            st_n   = IDLE;
            own_n  = '0;
            rem_n  = '0;
            half_n = 1'b0;
         end else if (tick) begin
            half_n = ~half;
            if (rem == 4'd1) begin
               st_n       = IDLE;
               own_n      = '0;
               rem_n      = '0;
               half_n     = 1'b0;
               exp_n[own] = 1'b1;
            end else begin
               rem_n = rem - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st      <= IDLE;
         own     <= '0;
         rem     <= '0;
         pend    <= '0;
         psel    <= '{default: '0};
         half    <= 1'b0;
         expired <= '0;
         tbl     <= '{T_ARM_DELAY, T_DRIVER_DELAY,
                      T_PASSENGER_DELAY, T_ALARM_ON};
      end else begin
         st      <= st_n;
         own     <= own_n;
         rem     <= rem_n;
         pend    <= pend_n;
         psel    <= psel_n;
         half    <= half_n;
         expired <= exp_n;
         if (reprogram && prog_value != 4'd0) begin
            tbl[prog_sel] <= prog_value;
         end
      end
   end

   assign busy           = (st == COUNT);
   assign owner          = own;
   assign remaining      = rem;
   assign one_hz_enable  = tick;
   assign half_hz_enable = half;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with CLK_HZ=4: grants, preemption,
// pending service, cancellation, table writes and mid-count reset.
module tb_timer_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] start = '0;
   logic [5:0] sel = '0;
   logic [2:0] cancel = '0;
   logic       reprogram = 1'b0;
   logic [1:0] prog_sel = '0;
   logic [3:0] prog_value = '0;
   logic [2:0] expired;
   logic       busy;
   logic [1:0] owner;
   logic [3:0] remaining;
   logic       one_hz_enable;
   logic       half_hz_enable;

   int total = 0;
   int bad = 0;

   timer_arbiter #(
      .CLK_HZ (4),
      .NREQ   (3)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .sel            (sel),
      .cancel         (cancel),
      .reprogram      (reprogram),
      .prog_sel       (prog_sel),
      .prog_value     (prog_value),
      .expired        (expired),
      .busy           (busy),
      .owner          (owner),
      .remaining      (remaining),
      .one_hz_enable  (one_hz_enable),
      .half_hz_enable (half_hz_enable)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // steps until expired is nonzero or the bound runs out
   task automatic run_wait(input int bound, output int n,
                           output logic [2:0] e);
      n = 0;
      e = '0;
      while (n < bound && e == 3'b000) begin
         step();
         n++;
         e = expired;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      total++;
      if ({expired, busy, owner, remaining, one_hz_enable,
           half_hz_enable} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0",
                  {expired, busy, owner, remaining,
                   one_hz_enable, half_hz_enable});
      end
      #2 reset = 1'b1;
      step();
   endtask

   task automatic test_single();
      int tog, hz;
      logic prev;
      start = 3'b010;
      sel = 6'b00_00_00;
      step();
      start = '0;
      total++;
      if (busy !== 1'b1 || owner !== 2'd1 || remaining !== 4'd6) begin
         bad++;
         $display("FAIL grant1 got busy=%b own=%0d rem=%0d want 1/1/6",
                  busy, owner, remaining);
      end
      tog = 0;
      hz = 0;
      prev = half_hz_enable;
      for (int i = 1; i <= 23; i++) begin
         step();
         if (half_hz_enable !== prev) tog++;
         prev = half_hz_enable;
         if (one_hz_enable === 1'b1) hz++;
         total++;
         if (expired !== 3'b000) begin
            bad++;
            $display("FAIL early_expire step=%0d got=%b want=000",
                     i, expired);
         end
      end
      total++;
      if (remaining !== 4'd1) begin
         bad++;
         $display("FAIL rem_before_end got=%0d want=1", remaining);
      end
      step();
      if (half_hz_enable !== prev) tog++;
      total++;
      if (expired !== 3'b010 || busy !== 1'b0 || remaining !== 4'd0) begin
         bad++;
         $display("FAIL expire1 got exp=%b busy=%b rem=%0d want 010/0/0",
                  expired, busy, remaining);
      end
      total++;
      if (tog != 6 || hz != 6) begin
         bad++;
         $display("FAIL half_one_hz got tog=%0d hz=%0d want 6/6", tog, hz);
      end
      step();
      total++;
      if (expired !== 3'b000) begin
         bad++;
         $display("FAIL expire_pulse_len got=%b want=000", expired);
      end
   endtask

   task automatic test_preempt();
      int n;
      logic [2:0] e;
      start = 3'b100;
      sel = 6'b10_00_00;
      step();
      start = '0;
      total++;
      if (owner !== 2'd2 || remaining !== 4'd15) begin
         bad++;
         $display("FAIL grant2 got own=%0d rem=%0d want 2/15",
                  owner, remaining);
      end
      repeat (5) step();
      start = 3'b001;
      sel = 6'b00_00_01;
      step();
      start = '0;
      total++;
      if (owner !== 2'd0 || remaining !== 4'd8 || busy !== 1'b1) begin
         bad++;
         $display("FAIL preempt got own=%0d rem=%0d want 0/8",
                  owner, remaining);
      end
      run_wait(60, n, e);
      total++;
      if (n != 32 || e !== 3'b001) begin
         bad++;
         $display("FAIL preempt_expire got n=%0d e=%b want 32/001", n, e);
      end
      run_wait(30, n, e);
      total++;
      if (e !== 3'b000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL discarded_job got e=%b busy=%b want 000/0",
                  e, busy);
      end
   endtask

   task automatic test_pending();
      int n;
      logic [2:0] e;
      start = 3'b001;
      sel = 6'b00_00_00;
      step();
      start = '0;
      repeat (2) step();
      start = 3'b100;
      sel = 6'b11_00_00;
      step();
      start = '0;
      total++;
      if (owner !== 2'd0 || remaining !== 4'd6) begin
         bad++;
         $display("FAIL no_preempt_low got own=%0d rem=%0d want 0/6",
                  owner, remaining);
      end
      run_wait(40, n, e);
      total++;
      if (n != 21 || e !== 3'b001 || busy !== 1'b0) begin
         bad++;
         $display("FAIL pend_first got n=%0d e=%b busy=%b want 21/001/0",
                  n, e, busy);
      end
      step();
      total++;
      if (busy !== 1'b1 || owner !== 2'd2 || remaining !== 4'd10) begin
         bad++;
         $display("FAIL pend_grant got busy=%b own=%0d rem=%0d want 1/2/10",
                  busy, owner, remaining);
      end
      run_wait(60, n, e);
      total++;
      if (n != 40 || e !== 3'b100) begin
         bad++;
         $display("FAIL pend_expire got n=%0d e=%b want 40/100", n, e);
      end
   endtask

   task automatic test_same_cycle_cancel();
      int n;
      logic [2:0] e;
      step();
      start = 3'b011;
      sel = 6'b00_01_00;
      step();
      start = '0;
      total++;
      if (owner !== 2'd0 || remaining !== 4'd6) begin
         bad++;
         $display("FAIL dual_first got own=%0d rem=%0d want 0/6",
                  owner, remaining);
      end
      run_wait(40, n, e);
      total++;
      if (n != 24 || e !== 3'b001) begin
         bad++;
         $display("FAIL dual_exp0 got n=%0d e=%b want 24/001", n, e);
      end
      step();
      total++;
      if (owner !== 2'd1 || remaining !== 4'd8) begin
         bad++;
         $display("FAIL dual_second got own=%0d rem=%0d want 1/8",
                  owner, remaining);
      end
      run_wait(50, n, e);
      total++;
      if (n != 32 || e !== 3'b010) begin
         bad++;
         $display("FAIL dual_exp1 got n=%0d e=%b want 32/010", n, e);
      end
      step();
      start = 3'b011;
      step();
      start = '0;
      repeat (3) step();
      cancel = 3'b010;
      step();
      cancel = '0;
      run_wait(40, n, e);
      total++;
      if (e !== 3'b001) begin
         bad++;
         $display("FAIL cancel_exp0 got e=%b want 001", e);
      end
      repeat (5) step();
      total++;
      if (busy !== 1'b0 || owner !== 2'd0) begin
         bad++;
         $display("FAIL cancel_pend got busy=%b own=%0d want 0/0",
                  busy, owner);
      end
   endtask

   task automatic test_reprogram();
      int n;
      logic [2:0] e;
      start = 3'b010;
      sel = 6'b00_00_00;
      step();
      start = '0;
      reprogram = 1'b1;
      prog_sel = 2'd3;
      prog_value = 4'd2;
      step();
      reprogram = 1'b0;
      run_wait(40, n, e);
      total++;
      if (n != 23 || e !== 3'b010) begin
         bad++;
         $display("FAIL reprog_running got n=%0d e=%b want 23/010", n, e);
      end
      step();
      start = 3'b001;
      sel = 6'b00_00_11;
      step();
      start = '0;
      total++;
      if (remaining !== 4'd2) begin
         bad++;
         $display("FAIL reprog_load got rem=%0d want 2", remaining);
      end
      run_wait(20, n, e);
      total++;
      if (n != 8 || e !== 3'b001) begin
         bad++;
         $display("FAIL reprog_expire got n=%0d e=%b want 8/001", n, e);
      end
      reprogram = 1'b1;
      prog_value = 4'd0;
      step();
      reprogram = 1'b0;
      start = 3'b001;
      step();
      start = '0;
      total++;
      if (remaining !== 4'd2) begin
         bad++;
         $display("FAIL zero_write got rem=%0d want 2", remaining);
      end
      run_wait(20, n, e);
   endtask

   task automatic test_reset_midcount();
      int n;
      logic [2:0] e;
      step();
      start = 3'b001;
      sel = 6'b00_00_00;
      step();
      start = '0;
      repeat (12) step();
      total++;
      if (remaining !== 4'd3) begin
         bad++;
         $display("FAIL mid_rem got rem=%0d want 3", remaining);
      end
      #1 reset = 1'b0;
      #1;
      total++;
      if ({expired, busy, owner, remaining, one_hz_enable,
           half_hz_enable} !== 13'd0) begin
         bad++;
         $display("FAIL async_reset got=%b want=0",
                  {expired, busy, owner, remaining,
                   one_hz_enable, half_hz_enable});
      end
      step();
      step();
      reset = 1'b1;
      run_wait(30, n, e);
      total++;
      if (e !== 3'b000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset got e=%b busy=%b want 000/0", e, busy);
      end
      start = 3'b010;
      sel = 6'b00_11_00;
      step();
      start = '0;
      total++;
      if (remaining !== 4'd10) begin
         bad++;
         $display("FAIL table_default got rem=%0d want 10", remaining);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_preempt();
      test_pending();
      test_same_cycle_cancel();
      test_reprogram();
      test_reset_midcount();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
